i2c_cfg_seq: RTL and testbench



---
 rtl/i2c_cfg_seq_if.sv | 20 ++
 rtl/i2c_cfg_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_cfg_seq.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cfg_seq_if.sv
// i2c_cfg_seq_if: command/response bus between the config sequencer and the byte-level I2C driver.
interface i2c_cfg_seq_if;
    logic        i2c_exec;
    logic        i2c_rh_wl;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_w;
    logic        i2c_done;
    logic        i2c_nack;
    logic [7:0]  i2c_data_r;

    modport master (
        output i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w,
        input  i2c_done, i2c_nack, i2c_data_r
    );

    modport slave (
        input  i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w,
        output i2c_done, i2c_nack, i2c_data_r
    );
endinterface

// File: rtl/i2c_cfg_seq.sv
// i2c_cfg_seq: table-driven I2C configuration sequencer (device reset, table walk, verify/retry).
// Optional macro CFG_SEQ_TIMEOUT_EN adds a watchdog on outstanding driver commands.
module i2c_cfg_seq #(
    parameter int unsigned IDX_W          = 6,
    parameter int unsigned RST_CYCLES     = 50000,
    parameter int unsigned POWERUP_WAIT   = 100000,
    parameter int unsigned DELAY_UNIT     = 50000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dev_rstn_out,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [25:0]      tbl_entry,
    i2c_cfg_seq_if.master    i2c,
    output logic             init_done,
    output logic             init_err,
    output logic [IDX_W-1:0] err_idx
);

    // One shared counter covers reset hold, power-up wait, delay ops and the watchdog.
    localparam longint unsigned DLY_MAX  = 64'(16'hFFFF) * 64'(DELAY_UNIT);
    localparam longint unsigned WAIT_MAX = (RST_CYCLES > POWERUP_WAIT) ? 64'(RST_CYCLES) : 64'(POWERUP_WAIT);
    localparam longint unsigned TMO_MAX  = (WAIT_MAX > 64'(TIMEOUT_CYCLES)) ? WAIT_MAX : 64'(TIMEOUT_CYCLES);
    localparam longint unsigned CNT_MAX  = (DLY_MAX > TMO_MAX) ? DLY_MAX : TMO_MAX;
    localparam int unsigned     CNT_W    = $clog2(CNT_MAX + 64'd1);
    localparam int unsigned     RTY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [1:0] OP_WRITE        = 2'b00;
    localparam logic [1:0] OP_WRITE_VERIFY = 2'b01;
    localparam logic [1:0] OP_DELAY        = 2'b10;
    localparam logic [1:0] OP_END          = 2'b11;

    localparam logic [3:0] S_RST_HOLD = 4'd0;
    localparam logic [3:0] S_PWR_WAIT = 4'd1;
    localparam logic [3:0] S_FETCH    = 4'd2;
    localparam logic [3:0] S_DECODE   = 4'd3;
    localparam logic [3:0] S_WR_ISSUE = 4'd4;
    localparam logic [3:0] S_WR_WAIT  = 4'd5;
    localparam logic [3:0] S_RD_ISSUE = 4'd6;
    localparam logic [3:0] S_RD_WAIT  = 4'd7;
    localparam logic [3:0] S_DLY      = 4'd8;
    localparam logic [3:0] S_NEXT     = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd10;
    localparam logic [3:0] S_ERR      = 4'd11;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [7:0]  data;
    } cfg_entry_t;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] rty_q, rty_d;
    cfg_entry_t       ent_q, ent_d;
    cfg_entry_t       entry_c;
    logic [IDX_W-1:0] idx_d;
    logic             rstn_d;
    logic             exec_q, exec_d;
    logic             rh_wl_q, rh_wl_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             done_d, err_d;
    logic [IDX_W-1:0] err_idx_d;
    logic             fail_c;

    assign entry_c        = tbl_entry;
    assign i2c.i2c_exec   = exec_q;
    assign i2c.i2c_rh_wl  = rh_wl_q;
    assign i2c.i2c_addr   = addr_q;
    assign i2c.i2c_data_w = wdata_q;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RST_HOLD;
            cnt_q        <= '0;
            rty_q        <= '0;
            ent_q        <= '0;
            tbl_idx      <= '0;
            dev_rstn_out <= 1'b0;
            exec_q       <= 1'b0;
            rh_wl_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            init_done    <= 1'b0;
            init_err     <= 1'b0;
            err_idx      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rty_q        <= rty_d;
            ent_q        <= ent_d;
            tbl_idx      <= idx_d;
            dev_rstn_out <= rstn_d;
            exec_q       <= exec_d;
            rh_wl_q      <= rh_wl_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            init_done    <= done_d;
            init_err     <= err_d;
            err_idx      <= err_idx_d;
        end
    end

    // Next-state and next-output logic; exec is a one-cycle pulse by default.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rty_d     = rty_q;
        ent_d     = ent_q;
        idx_d     = tbl_idx;
        rstn_d    = dev_rstn_out;
        exec_d    = 1'b0;
        rh_wl_d   = rh_wl_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_d    = init_done;
        err_d     = init_err;
        err_idx_d = err_idx;
        fail_c    = 1'b0;

        case (state_q)
            S_RST_HOLD: begin
                rstn_d = 1'b0;
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    rstn_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_PWR_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PWR_WAIT: begin
                if (cnt_q == CNT_W'(POWERUP_WAIT - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ent_d = entry_c;
                rty_d = '0;
                case (entry_c.op)
                    OP_WRITE, OP_WRITE_VERIFY: begin
                        exec_d  = 1'b1;
                        rh_wl_d = 1'b0;
                        addr_d  = entry_c.addr;
                        wdata_d = entry_c.data;
                        cnt_d   = '0;
                        state_d = S_WR_ISSUE;
                    end
                    OP_DELAY: begin
                        cnt_d   = CNT_W'(64'(entry_c.addr) * 64'(DELAY_UNIT));
                        state_d = S_DLY;
                    end
                    OP_END: begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_WR_ISSUE: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (i2c.i2c_done) begin
                    if (i2c.i2c_nack) begin
                        fail_c = 1'b1;
                    end else if (ent_q.op == OP_WRITE_VERIFY) begin
                        exec_d  = 1'b1;
                        rh_wl_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_RD_ISSUE;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
`ifdef CFG_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fail_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (i2c.i2c_done) begin
                    if (i2c.i2c_nack || (i2c.i2c_data_r != ent_q.data)) begin
                        fail_c = 1'b1;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
`ifdef CFG_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fail_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_DLY: begin
                // A zero count still spends one cycle here before moving on.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_NEXT: begin
                if (tbl_idx == '1) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = tbl_idx + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    rstn_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RST_HOLD;
                end
            end
            default: state_d = S_RST_HOLD;
        endcase

        // Shared retry path: rewrite the entry until the retry budget is spent.
        if (fail_c) begin
            if (rty_q < RTY_W'(MAX_RETRY)) begin
                rty_d   = rty_q + RTY_W'(1);
                exec_d  = 1'b1;
                rh_wl_d = 1'b0;
                cnt_d   = '0;
                state_d = S_WR_ISSUE;
            end else begin
                err_d     = 1'b1;
                err_idx_d = tbl_idx;
                state_d   = S_ERR;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// tb_i2c_cfg_seq: directed bench for i2c_cfg_seq with a behavioural ROM and I2C driver model.
module tb_i2c_cfg_seq;
    localparam int unsigned IDX_W          = 3;
    localparam int unsigned RST_CYCLES     = 4;
    localparam int unsigned POWERUP_WAIT   = 8;
    localparam int unsigned DELAY_UNIT     = 2;
    localparam int unsigned MAX_RETRY      = 2;
    localparam int unsigned TIMEOUT_CYCLES = 30;
    localparam int          BUDGET         = 2000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             dev_rstn_out;
    logic [IDX_W-1:0] tbl_idx;
    logic [25:0]      tbl_entry;
    logic             init_done;
    logic             init_err;
    logic [IDX_W-1:0] err_idx;

    i2c_cfg_seq_if bus ();

    i2c_cfg_seq #(
        .IDX_W(IDX_W), .RST_CYCLES(RST_CYCLES), .POWERUP_WAIT(POWERUP_WAIT),
        .DELAY_UNIT(DELAY_UNIT), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dev_rstn_out(dev_rstn_out),
        .tbl_idx(tbl_idx), .tbl_entry(tbl_entry), .i2c(bus),
        .init_done(init_done), .init_err(init_err), .err_idx(err_idx)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM holding the register table.
    logic [25:0] rom [8];
    always_ff @(posedge clk) tbl_entry <= rom[tbl_idx];

    // Driver model configuration and activity log.
    bit          drv_silent = 1'b0;
    int          drv_lat = 2;
    logic [16:0] nack_addr = 17'h1_0000;
    int          rd_bad_left = 0;
    logic [7:0]  rd_bad_val = 8'h00;
    logic [7:0]  dev_reg = 8'h00;
    int          n_wr = 0;
    int          n_rd = 0;
    int          n_exec = 0;
    int          gap_log [16];
    int          done_cyc = 0;
    logic        last_rh = 1'b0;
    logic [15:0] last_addr = 16'h0;
    logic [7:0]  last_data = 8'h0;
    bit          busy = 1'b0;
    int          lat_left = 0;
    logic        c_rh;
    logic [15:0] c_addr;
    logic [7:0]  c_data;

    function automatic logic [25:0] ent(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
        return {op, a, d};
    endfunction

    // Byte-level driver: accepts exec, holds it for drv_lat cycles, then pulses done.
    initial begin
        bus.i2c_done = 1'b0;
        bus.i2c_nack = 1'b0;
        bus.i2c_data_r = 8'h00;
        forever begin
            @(negedge clk);
            bus.i2c_done = 1'b0;
            bus.i2c_nack = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else if (busy) begin
                checks++;
                if (bus.i2c_exec !== 1'b0 || bus.i2c_rh_wl !== c_rh || bus.i2c_addr !== c_addr || bus.i2c_data_w !== c_data) begin
                    errors++;
                    $display("FAIL cmd_hold: got exec=%b rh_wl=%b addr=%h data=%h, want exec=0 rh_wl=%b addr=%h data=%h",
                             bus.i2c_exec, bus.i2c_rh_wl, bus.i2c_addr, bus.i2c_data_w, c_rh, c_addr, c_data);
                end
                if (lat_left == 0) begin
                    busy = 1'b0;
                    bus.i2c_done = 1'b1;
                    bus.i2c_nack = (!c_rh && {1'b0, c_addr} == nack_addr);
                    if (c_rh) begin
                        if (rd_bad_left > 0) begin
                            bus.i2c_data_r = rd_bad_val;
                            rd_bad_left--;
                        end else begin
                            bus.i2c_data_r = dev_reg;
                        end
                    end else if (!bus.i2c_nack) begin
                        dev_reg = c_data;
                    end
                    done_cyc = cyc;
                end else begin
                    lat_left--;
                end
            end else if (bus.i2c_exec === 1'b1) begin
                c_rh = bus.i2c_rh_wl;
                c_addr = bus.i2c_addr;
                c_data = bus.i2c_data_w;
                last_rh = c_rh;
                last_addr = c_addr;
                last_data = c_data;
                if (c_rh) n_rd++; else n_wr++;
                if (n_exec < 16) gap_log[n_exec] = cyc - done_cyc;
                n_exec++;
                if (!drv_silent) begin
                    busy = 1'b1;
                    lat_left = drv_lat;
                end
            end
        end
    end

    task automatic clear_log();
        n_wr = 0;
        n_rd = 0;
        n_exec = 0;
        for (int i = 0; i < 16; i++) gap_log[i] = 0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = ent(2'b11, 16'h0000, 8'h00);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_log();
        rst = 1'b0;
    endtask

    task automatic wait_end(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (init_done || init_err) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        clear_rom();
        rom[0] = ent(2'b00, 16'h1234, 8'hA5);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dev_rstn_out !== 1'b0 || bus.i2c_exec !== 1'b0 || bus.i2c_rh_wl !== 1'b0 || tbl_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_ctl: got rstn=%b exec=%b rh_wl=%b idx=%0d, want 0 0 0 0", dev_rstn_out, bus.i2c_exec, bus.i2c_rh_wl, tbl_idx);
        end
        checks++;
        if (bus.i2c_addr !== 16'h0 || bus.i2c_data_w !== 8'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h data=%h, want 0000 00", bus.i2c_addr, bus.i2c_data_w);
        end
        checks++;
        if (init_done !== 1'b0 || init_err !== 1'b0 || err_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_status: got done=%b err=%b err_idx=%0d, want 0 0 0", init_done, init_err, err_idx);
        end
        clear_log();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (dev_rstn_out === 1'b1) break;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rstn_low_cycles: got %0d, want 4", n);
        end
        // Power-up wait of 8, then FETCH and DECODE before the exec pulse.
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (bus.i2c_exec === 1'b1) break;
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL first_exec_latency: got %0d, want 10", n);
        end
    endtask

    task automatic test_write();
        bit to;
        wait_end(to);
        checks++;
        if (to) begin errors++; $display("FAIL write_timeout: got no end, want done"); end
        checks++;
        if (n_wr != 1 || n_rd != 0 || last_rh !== 1'b0 || last_addr !== 16'h1234 || last_data !== 8'hA5) begin
            errors++;
            $display("FAIL write_cmd: got wr=%0d rd=%0d rh=%b addr=%h data=%h, want 1 0 0 1234 a5", n_wr, n_rd, last_rh, last_addr, last_data);
        end
        checks++;
        if (init_done !== 1'b1 || init_err !== 1'b0) begin
            errors++;
            $display("FAIL write_status: got done=%b err=%b, want 1 0", init_done, init_err);
        end
    endtask

    task automatic test_verify_fail();
        bit to;
        clear_rom();
        rom[0] = ent(2'b01, 16'h00C0, 8'h5A);
        rd_bad_left = 3;
        rd_bad_val = 8'h5B;
        apply_reset();
        wait_end(to);
        checks++;
        if (to) begin errors++; $display("FAIL vfail_timeout: got no end, want err"); end
        checks++;
        if (n_wr != 3 || n_rd != 3 || last_rh !== 1'b1 || last_addr !== 16'h00C0) begin
            errors++;
            $display("FAIL vfail_pairs: got wr=%0d rd=%0d rh=%b addr=%h, want 3 3 1 00c0", n_wr, n_rd, last_rh, last_addr);
        end
        checks++;
        if (init_err !== 1'b1 || init_done !== 1'b0 || err_idx !== 3'd0) begin
            errors++;
            $display("FAIL vfail_status: got err=%b done=%b err_idx=%0d, want 1 0 0", init_err, init_done, err_idx);
        end
    endtask

    task automatic test_verify_retry();
        bit to;
        rd_bad_left = 1;
        apply_reset();
        wait_end(to);
        checks++;
        if (to) begin errors++; $display("FAIL vretry_timeout: got no end, want done"); end
        checks++;
        if (n_wr != 2 || n_rd != 2 || init_done !== 1'b1 || init_err !== 1'b0) begin
            errors++;
            $display("FAIL vretry: got wr=%0d rd=%0d done=%b err=%b, want 2 2 1 0", n_wr, n_rd, init_done, init_err);
        end
    endtask

    task automatic test_nack_err_idx();
        bit to;
        clear_rom();
        rom[0] = ent(2'b00, 16'h0010, 8'h11);
        rom[1] = ent(2'b00, 16'h0020, 8'h22);
        rom[2] = ent(2'b00, 16'h0030, 8'h33);
        nack_addr = 17'h0_0030;
        apply_reset();
        wait_end(to);
        nack_addr = 17'h1_0000;
        checks++;
        if (to) begin errors++; $display("FAIL nack_timeout: got no end, want err"); end
        checks++;
        if (n_wr != 5 || last_addr !== 16'h0030) begin
            errors++;
            $display("FAIL nack_writes: got wr=%0d addr=%h, want 5 0030", n_wr, last_addr);
        end
        checks++;
        if (init_err !== 1'b1 || init_done !== 1'b0 || err_idx !== 3'd2) begin
            errors++;
            $display("FAIL nack_status: got err=%b done=%b err_idx=%0d, want 1 0 2", init_err, init_done, err_idx);
        end
    endtask

    task automatic test_delay();
        bit to;
        clear_rom();
        rom[0] = ent(2'b00, 16'h0001, 8'h01);
        rom[1] = ent(2'b10, 16'h0003, 8'h00);
        rom[2] = ent(2'b00, 16'h0002, 8'h02);
        rom[3] = ent(2'b10, 16'h0000, 8'h00);
        rom[4] = ent(2'b00, 16'h0003, 8'h03);
        apply_reset();
        wait_end(to);
        checks++;
        if (to || n_wr != 3 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL delay_run: got timeout=%b wr=%0d done=%b, want 0 3 1", to, n_wr, init_done);
        end
        // done->exec is 4 back to back; a delay entry adds NEXT/FETCH/DECODE (3) plus its wait.
        checks++;
        if (gap_log[1] != 13) begin
            errors++;
            $display("FAIL delay3_gap: got %0d, want 13", gap_log[1]);
        end
        checks++;
        if (gap_log[2] != 8) begin
            errors++;
            $display("FAIL delay0_gap: got %0d, want 8", gap_log[2]);
        end
    endtask

    task automatic test_no_end();
        bit to;
        for (int i = 0; i < 8; i++) rom[i] = ent(2'b00, 16'h0100 + 16'(i), 8'h40 + 8'(i));
        apply_reset();
        wait_end(to);
        checks++;
        if (to || n_wr != 8 || tbl_idx !== 3'd7) begin
            errors++;
            $display("FAIL noend_walk: got timeout=%b wr=%0d idx=%0d, want 0 8 7", to, n_wr, tbl_idx);
        end
        checks++;
        if (last_addr !== 16'h0107 || last_data !== 8'h47 || init_done !== 1'b1 || init_err !== 1'b0) begin
            errors++;
            $display("FAIL noend_last: got addr=%h data=%h done=%b err=%b, want 0107 47 1 0", last_addr, last_data, init_done, init_err);
        end
        checks++;
        if (gap_log[1] != 4) begin
            errors++;
            $display("FAIL b2b_gap: got %0d, want 4", gap_log[1]);
        end
    endtask

    task automatic test_restart();
        bit to;
        int n;
        @(negedge clk);
        start = 1'b1;
        clear_log();
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (dev_rstn_out !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: got rstn=%b done=%b, want 0 0", dev_rstn_out, init_done);
        end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (dev_rstn_out === 1'b1) break;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL restart_rstn_cycles: got %0d, want 4", n);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_wr >= 1) break;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (dev_rstn_out !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: got rstn=%b, want 1", dev_rstn_out);
        end
        wait_end(to);
        checks++;
        if (to || n_wr != 8 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_run: got timeout=%b wr=%0d done=%b, want 0 8 1", to, n_wr, init_done);
        end
    endtask

`ifdef CFG_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit to;
        clear_rom();
        rom[0] = ent(2'b00, 16'h0042, 8'h77);
        drv_silent = 1'b1;
        apply_reset();
        wait_end(to);
        drv_silent = 1'b0;
        checks++;
        if (to || n_wr != 3 || n_rd != 0) begin
            errors++;
            $display("FAIL timeout_retries: got timeout=%b wr=%0d rd=%0d, want 0 3 0", to, n_wr, n_rd);
        end
        checks++;
        if (init_err !== 1'b1 || init_done !== 1'b0 || err_idx !== 3'd0) begin
            errors++;
            $display("FAIL timeout_status: got err=%b done=%b err_idx=%0d, want 1 0 0", init_err, init_done, err_idx);
        end
    endtask
`else
    task automatic test_hang_and_reset();
        clear_rom();
        rom[0] = ent(2'b00, 16'h0042, 8'h77);
        drv_silent = 1'b1;
        apply_reset();
        repeat (200) @(negedge clk);
        checks++;
        if (n_wr != 1 || init_done !== 1'b0 || init_err !== 1'b0 || bus.i2c_addr !== 16'h0042) begin
            errors++;
            $display("FAIL hang_wait: got wr=%0d done=%b err=%b addr=%h, want 1 0 0 0042", n_wr, init_done, init_err, bus.i2c_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dev_rstn_out !== 1'b0 || bus.i2c_exec !== 1'b0 || bus.i2c_addr !== 16'h0 || bus.i2c_data_w !== 8'h0) begin
            errors++;
            $display("FAIL midrun_reset: got rstn=%b exec=%b addr=%h data=%h, want 0 0 0000 00",
                     dev_rstn_out, bus.i2c_exec, bus.i2c_addr, bus.i2c_data_w);
        end
        drv_silent = 1'b0;
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_verify_fail();
        test_verify_retry();
        test_nack_err_idx();
        test_delay();
        test_no_end();
        test_restart();
`ifdef CFG_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_hang_and_reset();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
